// File: rtl/tx_ibuf_fifo.sv
// Frame-aware TX input buffer: words become readable only once their frame's eof beat commits.
// Latency: eof beat sampled at edge E0 -> first frame word on rd_data with rd_valid after edge E0+2.
// Backpressure: rd_ready stalls rd_data in place; beats offered while full are dropped and their frame is aborted.
module tx_ibuf_fifo #(
  parameter int AW        = 9,
  parameter int DW        = 64,
  parameter int AFULL_THR = 16
) (
  input  logic          clk,
  input  logic          reset_n,
  input  logic [DW-1:0] wr_data,
  input  logic          wr_en,
  input  logic          wr_eof,
  input  logic          wr_discard,
  output logic          full,
  output logic          afull,
  output logic [AW:0]   free_words,
  output logic          drop,
  output logic [DW-1:0] rd_data,
  output logic          rd_valid,
  input  logic          rd_ready
);

  localparam int          DEPTH   = 1 << AW;
  localparam logic [AW:0] DEPTH_P = {1'b1, {AW{1'b0}}};
  localparam logic [AW:0] ONE     = {{AW{1'b0}}, 1'b1};
  localparam logic [AW:0] AFULL_P = AFULL_THR[AW:0];

  logic [DW-1:0] mem [DEPTH];

  logic [AW:0]   wp_tmp, fs, wp_commit, rp, occ;
  logic          bad, run;
  logic          wq_en;
  logic [AW-1:0] wq_addr;
  logic [DW-1:0] wq_data;
  logic          cq_vld;
  logic [AW:0]   cq_ptr;
  logic          beat, take, rd_slot;

  assign occ        = wp_tmp - rp;
  assign full       = (occ == DEPTH_P);
  assign free_words = DEPTH_P - occ;
  assign afull      = (free_words <= AFULL_P);

  // run arms one edge after reset release so no beat lands on the release edge
  assign beat    = run & wr_en & ~wr_discard;
  assign take    = beat & ~full & ~bad;
  assign rd_slot = ~rd_valid | rd_ready;

  always_ff @(posedge clk) begin
    if (wq_en) mem[wq_addr] <= wq_data;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      run       <= 1'b0;
      wp_tmp    <= '0;
      fs        <= '0;
      wp_commit <= '0;
      rp        <= '0;
      bad       <= 1'b0;
      drop      <= 1'b0;
      wq_en     <= 1'b0;
      wq_addr   <= '0;
      wq_data   <= '0;
      cq_vld    <= 1'b0;
      cq_ptr    <= '0;
      rd_data   <= '0;
      rd_valid  <= 1'b0;
    end else begin
      run     <= 1'b1;
      wq_en   <= take;
      wq_addr <= wp_tmp[AW-1:0];
      wq_data <= wr_data;
      // commit lands on the same edge as the RAM write of the eof word
      cq_vld  <= take & wr_eof;
      cq_ptr  <= wp_tmp + ONE;
      drop    <= 1'b0;

      if (cq_vld) wp_commit <= cq_ptr;

      if (run & wr_discard) begin
        wp_tmp <= fs;
        bad    <= 1'b0;
      end else if (take) begin
        wp_tmp <= wp_tmp + ONE;
        if (wr_eof) fs <= wp_tmp + ONE;
      end else if (beat) begin
        if (wr_eof) begin
          wp_tmp <= fs;
          bad    <= 1'b0;
          drop   <= 1'b1;
        end else begin
          bad    <= 1'b1;
        end
      end

      if (rd_slot) begin
        if (rp != wp_commit) begin
          rd_data  <= mem[rp[AW-1:0]];
          rp       <= rp + ONE;
          rd_valid <= 1'b1;
        end else begin
          rd_valid <= 1'b0;
        end
      end
    end
  end

endmodule

// File: tb/tb_tx_ibuf_fifo.sv
// Bench for tx_ibuf_fifo: a default instance (AW=9) and a small one (AW=4) sharing stimulus,
// checked against a frame-level queue model of committed words.
module tb_tx_ibuf_fifo;

  logic        clk = 1'b0;
  logic        reset_n;
  logic [63:0] wr_data;
  logic        wr_en, wr_eof, wr_discard, rd_ready, sel;

  logic        a_full, a_afull, a_drop, a_rd_valid;
  logic [9:0]  a_free;
  logic [63:0] a_rd_data;
  logic        b_full, b_afull, b_drop, b_rd_valid;
  logic [4:0]  b_free;
  logic [63:0] b_rd_data;

  logic        o_full, o_afull, o_drop, o_rd_valid;
  logic [9:0]  o_free;
  logic [63:0] o_rd_data;

  int          n_cmp = 0;
  int          n_err = 0;
  int          drop_seen = 0;
  logic [63:0] exp_q[$];
  logic [63:0] cur_q[$];
  bit          doomed = 0, no_full = 0, rnd_rdy = 0, hold_chk = 0;
  logic [63:0] held;
  int          len, disc_at;

  always #5 clk = ~clk;

  tx_ibuf_fifo dut_a (
    .clk(clk), .reset_n(reset_n), .wr_data(wr_data),
    .wr_en(wr_en & ~sel), .wr_eof(wr_eof & ~sel), .wr_discard(wr_discard & ~sel),
    .full(a_full), .afull(a_afull), .free_words(a_free), .drop(a_drop),
    .rd_data(a_rd_data), .rd_valid(a_rd_valid), .rd_ready(rd_ready)
  );

  tx_ibuf_fifo #(.AW(4), .DW(64), .AFULL_THR(4)) dut_b (
    .clk(clk), .reset_n(reset_n), .wr_data(wr_data),
    .wr_en(wr_en & sel), .wr_eof(wr_eof & sel), .wr_discard(wr_discard & sel),
    .full(b_full), .afull(b_afull), .free_words(b_free), .drop(b_drop),
    .rd_data(b_rd_data), .rd_valid(b_rd_valid), .rd_ready(rd_ready)
  );

  assign o_full     = sel ? b_full     : a_full;
  assign o_afull    = sel ? b_afull    : a_afull;
  assign o_drop     = sel ? b_drop     : a_drop;
  assign o_rd_valid = sel ? b_rd_valid : a_rd_valid;
  assign o_rd_data  = sel ? b_rd_data  : a_rd_data;
  assign o_free     = sel ? {5'b0, b_free} : a_free;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    n_cmp++;
    assert (obs === expv) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
    end
  endtask

  task automatic tick();
    if (rnd_rdy) rd_ready = 1'($urandom_range(0, 1));
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    repeat (n) tick();
  endtask

  // model: words of a frame become expected output only when its eof beat is accepted
  task automatic beat(input logic [63:0] d, input logic eof, input logic disc);
    wr_data = d; wr_en = 1'b1; wr_eof = eof; wr_discard = disc;
    if (disc) cur_q.delete();
    else begin
      cur_q.push_back(d);
      if (eof) begin
        if (!doomed) foreach (cur_q[k]) exp_q.push_back(cur_q[k]);
        cur_q.delete();
      end
    end
    tick();
    wr_en = 1'b0; wr_eof = 1'b0; wr_discard = 1'b0;
  endtask

  task automatic drain(input string tag);
    rd_ready = 1'b1;
    for (int k = 0; k < 400 && (exp_q.size() != 0 || o_rd_valid); k++) tick();
    idle(2);
    chk({tag, "_left"}, 64'(exp_q.size()), 64'd0);
    chk({tag, "_free"}, 64'(o_free), sel ? 64'd16 : 64'd512);
  endtask

  always @(negedge clk) begin
    if (!reset_n) hold_chk = 0;
    else begin
      if (hold_chk) begin
        chk("hold_vld", 64'(o_rd_valid), 64'd1);
        chk("hold_dat", o_rd_data, held);
      end
      hold_chk = o_rd_valid & ~rd_ready;
      held     = o_rd_data;
      if (o_rd_valid & rd_ready) begin
        if (exp_q.size() > 0) chk("rd_data", o_rd_data, exp_q.pop_front());
        else chk("rd_unexpected", o_rd_data, 'x);
      end
      if (o_drop) drop_seen++;
      if (no_full) chk("full_never", 64'(o_full), 64'd0);
    end
  end

  initial begin
    reset_n = 1'b0; sel = 1'b0; wr_data = '0; wr_en = 1'b0; wr_eof = 1'b0;
    wr_discard = 1'b0; rd_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_vld",   64'(o_rd_valid), 64'd0);
    chk("rst_drop",  64'(o_drop),     64'd0);
    chk("rst_full",  64'(o_full),     64'd0);
    chk("rst_afull", 64'(o_afull),    64'd0);
    chk("rst_free",  64'(o_free),     64'd512);
    chk("rst_data",  o_rd_data,       64'd0);
    sel = 1'b1; #1;
    chk("rst_free_b",  64'(o_free),  64'd16);
    chk("rst_afull_b", 64'(o_afull), 64'd0);
    sel = 1'b0;
    @(negedge clk); #1 reset_n = 1'b1;
    @(posedge clk); #1;
    idle(2);

    // single 4-word frame, latency and order
    rd_ready = 1'b1;
    for (int i = 1; i <= 4; i++) beat(64'(i), i == 4, 1'b0);
    @(negedge clk);
    chk("lat_e0_vld", 64'(o_rd_valid), 64'd0);
    chk("free_after_wr", 64'(o_free), 64'd508);
    @(negedge clk);
    chk("lat_e1_vld", 64'(o_rd_valid), 64'd0);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("seq_vld", 64'(o_rd_valid), 64'd1);
      chk("seq_dat", o_rd_data, 64'(i + 1));
    end
    @(posedge clk); #1;
    drain("single");

    // discard mid-frame, then a clean frame
    for (int i = 0; i < 3; i++) beat(64'h11 + 64'(i), 1'b0, 1'b0);
    beat(64'hdead, 1'b0, 1'b1);
    chk("disc_free", 64'(o_free), 64'd512);
    idle(4);
    chk("disc_vld", 64'(o_rd_valid), 64'd0);
    beat(64'ha1, 1'b0, 1'b0);
    beat(64'ha2, 1'b1, 1'b0);
    drain("disc");

    // two committed frames read under toggling backpressure
    rd_ready = 1'b0;
    for (int i = 0; i < 16; i++) beat(64'h100 + 64'(i), i == 7 || i == 15, 1'b0);
    idle(2);
    chk("bp_vld", 64'(o_rd_valid), 64'd1);
    for (int k = 0; k < 40; k++) begin
      rd_ready = k[0];
      tick();
    end
    drain("bp");

    // random frames, gaps, discards and consumer stalls
    rnd_rdy = 1; no_full = 1;
    for (int f = 0; f < 30; f++) begin
      len     = int'($urandom_range(1, 10));
      disc_at = ($urandom_range(0, 5) == 0) ? int'($urandom_range(0, len - 1)) : -1;
      for (int j = 0; j < len; j++) begin
        if ($urandom_range(0, 3) == 0) idle(1);
        if (j == disc_at) begin
          beat({$urandom, $urandom}, 1'b0, 1'b1);
          break;
        end
        beat({$urandom, $urandom}, j == len - 1, 1'b0);
      end
    end
    rnd_rdy = 0;
    drain("rand");
    no_full = 0;

    // small buffer: pointer wrap under streaming
    sel = 1'b1; rd_ready = 1'b1; no_full = 1;
    idle(1);
    for (int f = 0; f < 50; f++)
      for (int j = 0; j < 5; j++) beat(64'(f * 16 + j + 1), j == 4, 1'b0);
    drain("wrap");
    no_full = 0;

    // overflow: 20-word frame into 16 slots with no reader
    rd_ready = 1'b0; doomed = 1; drop_seen = 0;
    for (int i = 0; i < 20; i++) begin
      beat(64'(200 + i), i == 19, 1'b0);
      if (i == 10) chk("ovf_afull_lo", 64'(o_afull), 64'd0);
      if (i == 11) begin
        chk("ovf_afull_hi", 64'(o_afull), 64'd1);
        chk("ovf_free4",    64'(o_free),  64'd4);
      end
      if (i == 14) chk("ovf_full_lo", 64'(o_full), 64'd0);
      if (i == 15) begin
        chk("ovf_full_hi", 64'(o_full), 64'd1);
        chk("ovf_free0",   64'(o_free), 64'd0);
      end
    end
    idle(3);
    doomed = 0;
    chk("ovf_drop_cnt", 64'(drop_seen), 64'd1);
    chk("ovf_vld",      64'(o_rd_valid), 64'd0);
    chk("ovf_free",     64'(o_free),     64'd16);
    chk("ovf_full_end", 64'(o_full),     64'd0);
    rd_ready = 1'b1;
    for (int i = 0; i < 3; i++) beat(64'hd1 + 64'(i), i == 2, 1'b0);
    drain("ovf_recover");
    chk("ovf_drop_once", 64'(drop_seen), 64'd1);

    // reset during the third word of a frame with a committed frame still unread
    rd_ready = 1'b0;
    for (int i = 0; i < 3; i++) beat(64'he1 + 64'(i), i == 2, 1'b0);
    beat(64'hf1, 1'b0, 1'b0);
    beat(64'hf2, 1'b0, 1'b0);
    wr_data = 64'hf3; wr_en = 1'b1;
    #2 reset_n = 1'b0;
    exp_q.delete(); cur_q.delete();
    @(posedge clk); #1 wr_en = 1'b0;
    @(negedge clk);
    chk("rstm_vld",  64'(o_rd_valid), 64'd0);
    chk("rstm_free", 64'(o_free),     64'd16);
    chk("rstm_full", 64'(o_full),     64'd0);
    @(negedge clk); #1 reset_n = 1'b1;
    @(posedge clk); #1;
    idle(3);
    chk("rstm_vld_after",  64'(o_rd_valid), 64'd0);
    chk("rstm_free_after", 64'(o_free),     64'd16);
    rd_ready = 1'b1;
    beat(64'hc1, 1'b0, 1'b0);
    beat(64'hc2, 1'b1, 1'b0);
    drain("rstm");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
